bcd_calendar_counter: RTL and testbench
=======================================

Name: bcd_calendar_counter

Overview:
- Registered BCD calendar (day/month/year) that advances one day per `advance` strobe.
- Applies Gregorian leap-year rules to a parametrised-width BCD year.
- Successor to the combinational 4-digit leap-year checker: the leap decision is now internal and drives February length; loads are validated; wrap events are flagged.
- Sits between the day-tick source and the date display/logging logic.

Parameters:
- YEAR_DIGITS, 4, number of BCD year digits; legal range 4..8, elaboration error outside it.
- RESET_YEAR, 1, reset year as a binary integer; converted to BCD at elaboration; must fit in YEAR_DIGITS digits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- load  in  1  load the date from the load_* inputs
- load_day  in  8  BCD day, 2 digits
- load_month  in  8  BCD month, 2 digits
- load_year  in  4*YEAR_DIGITS  BCD year; digit 0 = ones, in bits [3:0]
- advance  in  1  increment the date by one day
- day  out  8  current BCD day
- month  out  8  current BCD month
- year  out  4*YEAR_DIGITS  current BCD year
- leap  out  1  current year is a leap year
- month_wrap  out  1  one-cycle pulse: the last advance crossed a month boundary
- year_wrap  out  1  one-cycle pulse: the last advance crossed a year boundary
- overflow  out  1  sticky: the year wrapped from all-9s to all-0s
- load_err  out  1  one-cycle pulse: the last load was rejected

Behaviour:
- Reset, asynchronous:
  - day = 8'h01, month = 8'h01, year = BCD(RESET_YEAR).
  - month_wrap = year_wrap = overflow = load_err = 0.
- All state changes happen on the rising clk edge. Outputs update the cycle after the strobe: latency 1.
- Priority: load over advance. When load = 1, advance that cycle is ignored, whether or not the load is accepted.
- Load validation: reject the load if any of the following hold.
  - Any nibble of the load inputs > 9.
  - load_month is 00 or > 12.
  - load_day is 00 or > days_in_month(load_month, leap(load_year)).
- On reject: state is unchanged and load_err pulses for 1 cycle.
- On accept: the registers take the load values and overflow clears.
- leap is combinational from the year register, with no extra latency. leap = 1 iff:
  - tens/ones digits form a value divisible by 4 and that value is not 00; or
  - tens/ones = 00 and the thousands/hundreds digits form a value divisible by 4.
  - Divisibility of a two-digit BCD value by 4: the tens digit is even and ones ∈ {0,4,8}, or the tens digit is odd and ones ∈ {2,6}.
  - Digits above the thousands digit do not affect leap. Year 0000 is leap.
- days_in_month:
  - 04, 06, 09, 11 → 30.
  - 02 → 28 + leap.
  - All other months → 31.
- Advance, with no load:
  - If day < days_in_month: increment day in BCD (09 → 10, 19 → 20).
  - Else: day = 01 and month_wrap pulses.
  - If month was 12: month = 01, the year increments with BCD ripple carry, and year_wrap pulses.
  - Otherwise month increments in BCD (09 → 10).
- Year all-9s + 1 → all-0s; overflow sets and stays set until reset or an accepted load.
- month_wrap and year_wrap are 0 in every cycle not following a qualifying advance.
- Internal state is always a legal date. The next-date logic must not depend on out-of-range states, which are unreachable.
- Reset asserted mid-operation overrides load and advance immediately.

Optional Feature:
- Macro CAL_JULIAN_EN.
- Defined: leap = 1 iff tens/ones is divisible by 4, including 00; the century rule is removed; 1900 is leap.
- Undefined: the Gregorian rule above.
- Everything else is identical in both builds.

Test Plan:
- Reset, RESET_YEAR=1 → day=01, month=01, year=0001, all flags 0. Advance ×31 → 01/02/0001; month_wrap pulses on the 31st advance only.
- Load 28/02/2023, advance → 01/03/2023, leap=0, month_wrap=1. Load 28/02/2024, advance → 29/02/2024, leap=1, then advance → 01/03.
- Load year 1900 → leap=0 (leap=1 with CAL_JULIAN_EN). Load year 2000 → leap=1. Load year 2100 → leap=0.
- Load 31/12/9999, advance → 01/01/0000, month_wrap = year_wrap = overflow = 1, leap=1. Advance again → overflow still 1. Accepted load → overflow 0.
- Load 31/04/2020, load 29/02/2023, load 0A/01/2020, load 15/13/2020 → each: load_err pulses 1 cycle, date unchanged.
- load=1 and advance=1 together with 10/05/2020 → exactly 10/05/2020, no increment. Assert reset while advance=1 → reset values on the same edge.

Source files
------------

// File: rtl/bcd_calendar_counter.sv
// bcd_calendar_counter
//   Registered BCD calendar (day/month/year). The date advances by one day
//   for each advance strobe. February length follows the leap-year rule.
//   Loads are validated before they are taken, and month, year and
//   year-overflow events are flagged.
//
//   Optional build macro: CAL_JULIAN_EN
//     Defined   -> Julian leap rule: every year whose tens/ones value is
//                  divisible by 4 is a leap year, 00 included.
//     Undefined -> Gregorian leap rule, with the century exception.
//
// Parameters
//   YEAR_DIGITS : number of BCD year digits, 4..8
//   RESET_YEAR  : reset year as a binary integer; must fit in YEAR_DIGITS
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   load        in   load the date from the load_* inputs (wins over advance)
//   load_day    in   BCD day to load
//   load_month  in   BCD month to load
//   load_year   in   BCD year to load, digit 0 in bits [3:0]
//   advance     in   advance the date by one day
//   day         out  current BCD day
//   month       out  current BCD month
//   year        out  current BCD year
//   leap        out  the current year is a leap year (combinational)
//   month_wrap  out  one-cycle pulse: the last advance crossed a month
//   year_wrap   out  one-cycle pulse: the last advance crossed a year
//   overflow    out  sticky: the year wrapped from all-9s to all-0s
//   load_err    out  one-cycle pulse: the last load was rejected
module bcd_calendar_counter #(
  parameter int YEAR_DIGITS = 4,
  parameter int RESET_YEAR  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [7:0]               load_day,
  input  logic [7:0]               load_month,
  input  logic [4*YEAR_DIGITS-1:0] load_year,
  input  logic                     advance,
  output logic [7:0]               day,
  output logic [7:0]               month,
  output logic [4*YEAR_DIGITS-1:0] year,
  output logic                     leap,
  output logic                     month_wrap,
  output logic                     year_wrap,
  output logic                     overflow,
  output logic                     load_err
);

  localparam int YW = 4 * YEAR_DIGITS;

  // ---------------------------------------------------------------------
  // Elaboration-time helpers
  // ---------------------------------------------------------------------
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] bin_to_bcd(input int v);
    logic [31:0] r;
    int          rem;
    r   = 32'd0;
    rem = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  generate
    if (YEAR_DIGITS < 4 || YEAR_DIGITS > 8) begin : g_bad_digits
      $error("bcd_calendar_counter: YEAR_DIGITS must be in 4..8");
    end
    if (RESET_YEAR < 0 || RESET_YEAR >= pow10(YEAR_DIGITS)) begin : g_bad_reset_year
      $error("bcd_calendar_counter: RESET_YEAR does not fit in YEAR_DIGITS digits");
    end
  endgenerate

  localparam logic [31:0]   RESET_BCD_FULL = bin_to_bcd(RESET_YEAR);
  localparam logic [YW-1:0] RESET_YEAR_BCD = RESET_BCD_FULL[YW-1:0];

  // ---------------------------------------------------------------------
  // Calendar arithmetic helpers
  // ---------------------------------------------------------------------
  // A two-digit BCD value is divisible by 4 when the tens digit is even and
  // the ones digit is 0/4/8, or the tens digit is odd and the ones is 2/6.
  function automatic logic div4_bcd(input logic [3:0] tens, input logic [3:0] ones);
    logic r;
    if (tens[0] == 1'b0) begin
      r = (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
    end else begin
      r = (ones == 4'd2) || (ones == 4'd6);
    end
    return r;
  endfunction

  // Only the low four digits matter; higher digits never change the result.
  function automatic logic is_leap(input logic [15:0] y);
    logic r;
`ifdef CAL_JULIAN_EN
    r = div4_bcd(y[7:4], y[3:0]);
`else
    if (y[7:0] == 8'h00) begin
      r = div4_bcd(y[15:12], y[11:8]);
    end else begin
      r = div4_bcd(y[7:4], y[3:0]);
    end
`endif
    return r;
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic lp);
    logic [7:0] r;
    case (m)
      8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
      8'h02:                      r = lp ? 8'h29 : 8'h28;
      default:                    r = 8'h31;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Ripple-carry BCD increment of the year; the MSB is the carry out,
  // which is set only when the year was all 9s.
  function automatic logic [YW:0] year_inc(input logic [YW-1:0] y);
    logic [YW-1:0] r;
    logic          c;
    r = y;
    c = 1'b1;
    for (int i = 0; i < YEAR_DIGITS; i++) begin
      if (c) begin
        if (y[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = y[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end else begin
        r[4*i +: 4] = y[4*i +: 4];
      end
    end
    return {c, r};
  endfunction

  function automatic logic year_nibbles_ok(input logic [YW-1:0] y);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < YEAR_DIGITS; i++) begin
      if (y[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // ---------------------------------------------------------------------
  // State and next-state signals
  // ---------------------------------------------------------------------
  logic [7:0]    day_r, month_r;
  logic [YW-1:0] year_r;
  logic          month_wrap_r, year_wrap_r, overflow_r, load_err_r;

  logic          leap_s;
  logic          load_leap_s;
  logic [7:0]    load_dim_s;
  logic          load_ok_s;
  logic [7:0]    cur_dim_s;
  logic [YW:0]   year_inc_s;
  logic [7:0]    next_day_s, next_month_s;
  logic [YW-1:0] next_year_s;
  logic          next_mwrap_s, next_ywrap_s, next_ovf_s;

  assign leap_s = is_leap(year_r[15:0]);

  // Load validation: every nibble must be a decimal digit, and the month
  // and day must be in range for the year being loaded.
  always_comb begin
    load_leap_s = is_leap(load_year[15:0]);
    load_dim_s  = days_in_month(load_month, load_leap_s);
    load_ok_s   = 1'b1;
    if (!year_nibbles_ok(load_year) ||
        load_day[3:0] > 4'd9 || load_day[7:4] > 4'd9 ||
        load_month[3:0] > 4'd9 || load_month[7:4] > 4'd9) begin
      load_ok_s = 1'b0;
    end else if (load_month == 8'h00 || load_month > 8'h12) begin
      load_ok_s = 1'b0;
    end else if (load_day == 8'h00 || load_day > load_dim_s) begin
      load_ok_s = 1'b0;
    end else begin
      load_ok_s = 1'b1;
    end
  end

  // Next date for one advance. The state is always a legal date, so a
  // plain BCD magnitude compare against the month length is sufficient.
  always_comb begin
    cur_dim_s    = days_in_month(month_r, leap_s);
    year_inc_s   = year_inc(year_r);
    next_day_s   = day_r;
    next_month_s = month_r;
    next_year_s  = year_r;
    next_mwrap_s = 1'b0;
    next_ywrap_s = 1'b0;
    next_ovf_s   = 1'b0;
    if (day_r < cur_dim_s) begin
      next_day_s = bcd_inc2(day_r);
    end else begin
      next_day_s   = 8'h01;
      next_mwrap_s = 1'b1;
      if (month_r == 8'h12) begin
        next_month_s = 8'h01;
        next_year_s  = year_inc_s[YW-1:0];
        next_ywrap_s = 1'b1;
        next_ovf_s   = year_inc_s[YW];
      end else begin
        next_month_s = bcd_inc2(month_r);
      end
    end
  end

  // Date registers and event flags; a load takes priority over an advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      day_r        <= 8'h01;
      month_r      <= 8'h01;
      year_r       <= RESET_YEAR_BCD;
      month_wrap_r <= 1'b0;
      year_wrap_r  <= 1'b0;
      overflow_r   <= 1'b0;
      load_err_r   <= 1'b0;
    end else if (load) begin
      month_wrap_r <= 1'b0;
      year_wrap_r  <= 1'b0;
      if (load_ok_s) begin
        day_r      <= load_day;
        month_r    <= load_month;
        year_r     <= load_year;
        overflow_r <= 1'b0;
        load_err_r <= 1'b0;
      end else begin
        load_err_r <= 1'b1;
      end
    end else if (advance) begin
      day_r        <= next_day_s;
      month_r      <= next_month_s;
      year_r       <= next_year_s;
      month_wrap_r <= next_mwrap_s;
      year_wrap_r  <= next_ywrap_s;
      overflow_r   <= overflow_r | next_ovf_s;
      load_err_r   <= 1'b0;
    end else begin
      month_wrap_r <= 1'b0;
      year_wrap_r  <= 1'b0;
      load_err_r   <= 1'b0;
    end
  end

  assign day        = day_r;
  assign month      = month_r;
  assign year       = year_r;
  assign leap       = leap_s;
  assign month_wrap = month_wrap_r;
  assign year_wrap  = year_wrap_r;
  assign overflow   = overflow_r;
  assign load_err   = load_err_r;

endmodule

// File: tb/tb_bcd_calendar_counter.sv
// Directed self-checking bench for bcd_calendar_counter with the default
// parameters (YEAR_DIGITS = 4, RESET_YEAR = 1).
module tb_bcd_calendar_counter;

  logic        clk;
  logic        reset;
  logic        load;
  logic [7:0]  load_day;
  logic [7:0]  load_month;
  logic [15:0] load_year;
  logic        advance;
  logic [7:0]  day;
  logic [7:0]  month;
  logic [15:0] year;
  logic        leap;
  logic        month_wrap;
  logic        year_wrap;
  logic        overflow;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  bcd_calendar_counter #(
    .YEAR_DIGITS(4),
    .RESET_YEAR (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_day  (load_day),
    .load_month(load_month),
    .load_year (load_year),
    .advance   (advance),
    .day       (day),
    .month     (month),
    .year      (year),
    .leap      (leap),
    .month_wrap(month_wrap),
    .year_wrap (year_wrap),
    .overflow  (overflow),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_date(input string tag, input logic [7:0] d, input logic [7:0] m,
                            input logic [15:0] y);
    check_value({tag, " day"}, {24'd0, day}, {24'd0, d});
    check_value({tag, " month"}, {24'd0, month}, {24'd0, m});
    check_value({tag, " year"}, {16'd0, year}, {16'd0, y});
  endtask

  task automatic check_flags(input string tag, input logic mw, input logic yw,
                             input logic ov, input logic le);
    check_value({tag, " month_wrap"}, {31'd0, month_wrap}, {31'd0, mw});
    check_value({tag, " year_wrap"}, {31'd0, year_wrap}, {31'd0, yw});
    check_value({tag, " overflow"}, {31'd0, overflow}, {31'd0, ov});
    check_value({tag, " load_err"}, {31'd0, load_err}, {31'd0, le});
  endtask

  // Wait for the next rising edge, then settle 1 time unit before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] d, input logic [7:0] m, input logic [15:0] y);
    load       = 1'b1;
    load_day   = d;
    load_month = m;
    load_year  = y;
    step();
    load = 1'b0;
  endtask

  task automatic do_advance();
    advance = 1'b1;
    step();
    advance = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    load       = 1'b0;
    advance    = 1'b0;
    load_day   = 8'h00;
    load_month = 8'h00;
    load_year  = 16'h0000;
    step();
    step();
    check_date("reset", 8'h01, 8'h01, 16'h0001);
    check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_value("reset leap", {31'd0, leap}, 32'd0);
    reset = 1'b0;

    // 31 advances through January; month_wrap only on the last one.
    advance = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      step();
      check_value($sformatf("jan adv%0d month_wrap", i), {31'd0, month_wrap},
                  (i == 31) ? 32'd1 : 32'd0);
      if (i == 9) begin
        check_value("jan day 09->10", {24'd0, day}, 32'h10);
      end
    end
    advance = 1'b0;
    check_date("after 31 adv", 8'h01, 8'h02, 16'h0001);
    step();
    check_value("idle month_wrap", {31'd0, month_wrap}, 32'd0);

    // Non-leap February end.
    do_load(8'h28, 8'h02, 16'h2023);
    check_date("load 2023", 8'h28, 8'h02, 16'h2023);
    check_value("load 2023 load_err", {31'd0, load_err}, 32'd0);
    do_advance();
    check_date("2023 feb end", 8'h01, 8'h03, 16'h2023);
    check_value("2023 leap", {31'd0, leap}, 32'd0);
    check_flags("2023 feb end", 1'b1, 1'b0, 1'b0, 1'b0);

    // Leap February end.
    do_load(8'h28, 8'h02, 16'h2024);
    do_advance();
    check_date("2024 feb 29", 8'h29, 8'h02, 16'h2024);
    check_value("2024 leap", {31'd0, leap}, 32'd1);
    check_value("2024 feb 29 month_wrap", {31'd0, month_wrap}, 32'd0);
    do_advance();
    check_date("2024 mar 1", 8'h01, 8'h03, 16'h2024);
    check_value("2024 mar 1 month_wrap", {31'd0, month_wrap}, 32'd1);

    // Month 09 -> 10 carry.
    do_load(8'h30, 8'h09, 16'h2021);
    do_advance();
    check_date("sep->oct", 8'h01, 8'h10, 16'h2021);

    // Century years.
    do_load(8'h01, 8'h01, 16'h1900);
`ifdef CAL_JULIAN_EN
    check_value("leap 1900", {31'd0, leap}, 32'd1);
`else
    check_value("leap 1900", {31'd0, leap}, 32'd0);
`endif
    do_load(8'h01, 8'h01, 16'h2000);
    check_value("leap 2000", {31'd0, leap}, 32'd1);
    do_load(8'h01, 8'h01, 16'h2100);
`ifdef CAL_JULIAN_EN
    check_value("leap 2100", {31'd0, leap}, 32'd1);
`else
    check_value("leap 2100", {31'd0, leap}, 32'd0);
`endif

    // Ordinary year change without overflow.
    do_load(8'h31, 8'h12, 16'h2023);
    do_advance();
    check_date("new year 2024", 8'h01, 8'h01, 16'h2024);
    check_flags("new year 2024", 1'b1, 1'b1, 1'b0, 1'b0);

    // Year overflow 9999 -> 0000.
    do_load(8'h31, 8'h12, 16'h9999);
    do_advance();
    check_date("overflow", 8'h01, 8'h01, 16'h0000);
    check_flags("overflow", 1'b1, 1'b1, 1'b1, 1'b0);
    check_value("leap 0000", {31'd0, leap}, 32'd1);
    do_advance();
    check_date("after overflow", 8'h02, 8'h01, 16'h0000);
    check_flags("after overflow", 1'b0, 1'b0, 1'b1, 1'b0);

    // Load and advance together: load wins, overflow clears.
    advance = 1'b1;
    do_load(8'h10, 8'h05, 16'h2020);
    advance = 1'b0;
    check_date("load+advance", 8'h10, 8'h05, 16'h2020);
    check_flags("load+advance", 1'b0, 1'b0, 1'b0, 1'b0);

    // Rejected loads leave the date untouched.
    do_load(8'h31, 8'h04, 16'h2020);
    check_value("rej 31/04 load_err", {31'd0, load_err}, 32'd1);
    check_date("rej 31/04", 8'h10, 8'h05, 16'h2020);
    do_load(8'h29, 8'h02, 16'h2023);
    check_value("rej 29/02/2023 load_err", {31'd0, load_err}, 32'd1);
    check_date("rej 29/02/2023", 8'h10, 8'h05, 16'h2020);
    do_load(8'h0A, 8'h01, 16'h2020);
    check_value("rej 0A/01 load_err", {31'd0, load_err}, 32'd1);
    check_date("rej 0A/01", 8'h10, 8'h05, 16'h2020);
    advance = 1'b1;
    do_load(8'h15, 8'h13, 16'h2020);
    advance = 1'b0;
    check_value("rej 15/13 load_err", {31'd0, load_err}, 32'd1);
    check_date("rej 15/13 with advance", 8'h10, 8'h05, 16'h2020);
    step();
    check_value("load_err pulse ends", {31'd0, load_err}, 32'd0);
    do_load(8'h29, 8'h02, 16'h2024);
    check_value("accept 29/02/2024 load_err", {31'd0, load_err}, 32'd0);
    check_date("accept 29/02/2024", 8'h29, 8'h02, 16'h2024);

    // Reset asserted while advancing takes effect immediately.
    advance = 1'b1;
    step();
    check_date("pre-reset advance", 8'h01, 8'h03, 16'h2024);
    reset = 1'b1;
    #1;
    check_date("async reset", 8'h01, 8'h01, 16'h0001);
    check_flags("async reset", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_date("held reset", 8'h01, 8'h01, 16'h0001);
    advance = 1'b0;
    reset   = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
